// File: rtl/alu_iter_sequencer.sv
// Shares one ALU between the EX stage and an iterative MULTU/DIVU engine.
// The engine takes the ALU for WIDTH add/sub steps, then updates HI/LO.
module alu_iter_sequencer #(
  parameter int unsigned WIDTH  = 32,
  parameter logic [3:0]  OP_ADD = 4'b0010,
  parameter logic [3:0]  OP_SUB = 4'b0110
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] ex_a,
  input  logic [WIDTH-1:0] ex_b,
  input  logic [3:0]       ex_ctrl,
  output logic [WIDTH-1:0] ex_result,
  output logic             ex_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] w_hi_q, w_hi_d;   // MULTU: P_hi / DIVU: remainder R
  logic [WIDTH-1:0] w_lo_q, w_lo_d;   // MULTU: P_lo (multiplier) / DIVU: quotient Q
  logic [WIDTH-1:0] opnd_q, opnd_d;   // MULTU: multiplicand / DIVU: divisor
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             mul_carry;
  logic [WIDTH:0]   div_rext;
  logic             div_take;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  // ALU results go straight back to EX; EX ignores them while stalled.
  assign ex_result = alu_result;
  assign ex_zero   = alu_zero;
  assign busy      = busy_q;
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

  // One iteration of either algorithm, using the shared ALU's result.
  always_comb begin
    mul_carry = (alu_result < w_hi_q);
    div_rext  = {w_hi_q, w_lo_q[WIDTH-1]};
    div_take  = div_rext[WIDTH] | (div_rext[WIDTH-1:0] >= opnd_q);
    if (state_q == S_DIV) begin
      step_hi = div_take ? alu_result : div_rext[WIDTH-1:0];
      step_lo = {w_lo_q[WIDTH-2:0], div_take};
    end else if (w_lo_q[0]) begin
      step_hi = {mul_carry, alu_result[WIDTH-1:1]};
      step_lo = {alu_result[0], w_lo_q[WIDTH-1:1]};
    end else begin
      step_hi = {1'b0, w_hi_q[WIDTH-1:1]};
      step_lo = {w_hi_q[0], w_lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    alu_a    = ex_a;
    alu_b    = ex_b;
    alu_ctrl = ex_ctrl;
    if (busy_q) begin
      alu_b = opnd_q;
      if (state_q == S_DIV) begin
        alu_a    = div_rext[WIDTH-1:0];
        alu_ctrl = OP_SUB;
      end else begin
        alu_a    = w_hi_q;
        alu_ctrl = OP_ADD;
      end
    end
  end

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path through the case leaves a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    w_hi_d  = w_hi_q;
    w_lo_d  = w_lo_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = op_div ? S_DIV : S_MUL;
          cnt_d   = '0;
          w_hi_d  = '0;
          w_lo_d  = op_div ? op_a : op_b;
          opnd_d  = op_div ? op_b : op_a;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL, S_DIV: begin
        w_hi_d = step_hi;
        w_lo_d = step_lo;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = S_DONE;
          cnt_d   = '0;
          hi_d    = step_hi;
          lo_d    = step_lo;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_MUL) || (state_d == S_DIV);
    done_d = (state_d == S_DONE);
  end

  // NOTE: state registers use non-blocking assignment so all flops update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      w_hi_q  <= '0;
      w_lo_q  <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_hi_q  <= w_hi_d;
      w_lo_q  <= w_lo_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule
